// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps the shared ALU, unified memory and register file
// through fetch/decode/execute/memory/write-back, stalling on the memory-ready handshake.
module multicycle_control #(
    parameter logic [1:0] RA_SEL = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXEC_R    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_EXEC_I    = 4'd9;
    localparam logic [3:0] S_I_WB      = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic [3:0] w_decode_next;
    logic       w_op_illegal;
    logic [5:0] r_op_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; reset here is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op_q  <= 6'h00;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_op_q <= OP;
            end
        end
    end

    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise an unassigned path would infer a latch.
    always_comb begin
        w_decode_next = S_FETCH;
        w_op_illegal  = 1'b0;
        case (OP)
            OP_RTYPE:                        w_decode_next = S_EXEC_R;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_decode_next = S_EXEC_I;
            OP_LW, OP_SW:                    w_decode_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                  w_decode_next = S_BRANCH;
            OP_J, OP_JAL:                    w_decode_next = S_JUMP;
            default:                         w_op_illegal  = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_IDLE:      w_state_next = S_FETCH;
            S_FETCH:     w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    w_state_next = w_decode_next;
            S_EXEC_R:    w_state_next = S_R_WB;
            S_EXEC_I:    w_state_next = S_I_WB;
            S_MEM_ADDR:  w_state_next = (r_op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            default:     w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b100;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUOp      = 3'b100;
                illegal_op = w_op_illegal;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
            end
            S_R_WB: begin
                RegDst     = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (r_op_q)
                    OP_ORI:  ALUOp = 3'b101;
                    OP_ANDI: ALUOp = 3'b110;
                    OP_LUI:  ALUOp = 3'b000;
                    default: ALUOp = 3'b100;
                endcase
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b100;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg   = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (r_op_q == OP_BNE);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                // $31 gets the PC already advanced to PC+4 during FETCH.
                if (r_op_q == OP_JAL) begin
                    RegDst   = RA_SEL;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one vector per clock cycle with
// hand-computed output bundles, plus cycle-count sequences for whole instructions.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic       RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [2:0] ALUOp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control #(.RA_SEL(2'b10)) dut (
        .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    logic [21:0] got;
    assign got = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  instr_done, illegal_op};

    function automatic logic [21:0] pk(input int pcw, input int pcc, input int bne,
                                       input int iord, input int mr, input int mw,
                                       input int irw, input int rd, input int m2r,
                                       input int rw, input int sa, input int sb,
                                       input int aop, input int pcs, input int done,
                                       input int ill);
        return {pcw[0], pcc[0], bne[0], iord[0], mr[0], mw[0], irw[0], rd[1:0],
                m2r[1:0], rw[0], sa[0], sb[1:0], aop[2:0], pcs[1:0], done[0], ill[0]};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [21:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rst, input int op, input int rdy,
                       input logic [21:0] exp, input string name);
        vec_t v;
        v.rst  = rst[0];
        v.op   = op[5:0];
        v.rdy  = rdy[0];
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [21:0] actual, input logic [21:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got=%06h expected=%06h", name, actual, expected);
        end
    endtask

    task automatic run_count(input logic [5:0] op, input int exp_n, input string name);
        int  n;
        bit  seen;
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; OP = op;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            #1;
            if (instr_done) begin
                seen = 1'b1;
                n = i;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!seen || n != exp_n) begin
            failures++;
            $display("FAIL %s: cycles=%0d (seen=%0d) expected=%0d", name, n, seen, exp_n);
        end
    endtask

    logic [21:0] E_Z, E_FETCH, E_FETCH_W, E_DEC, E_DEC_ILL, E_EXR, E_RWB;
    logic [21:0] E_EXI_ADD, E_EXI_OR, E_EXI_AND, E_EXI_LUI, E_IWB, E_MADDR;
    logic [21:0] E_MRD, E_MWB, E_MWR, E_MWR_DONE, E_BEQ, E_BNE, E_J, E_JAL;

    initial begin
        //                pcw pcc bne iord mr mw irw rd m2r rw sa sb aop pcs done ill
        E_Z        = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_FETCH    = pk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        E_FETCH_W  = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        E_DEC      = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 0);
        E_DEC_ILL  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 1);
        E_EXR      = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
        E_RWB      = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        E_EXI_ADD  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0, 0, 0);
        E_EXI_OR   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5, 0, 0, 0);
        E_EXI_AND  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 6, 0, 0, 0);
        E_EXI_LUI  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        E_IWB      = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        E_MADDR    = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0, 0, 0);
        E_MRD      = pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_MWB      = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        E_MWR      = pk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_MWR_DONE = pk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        E_BEQ      = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0);
        E_BNE      = pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0);
        E_J        = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
        E_JAL      = pk(1, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 2, 1, 0);

        // One entry per cycle; OP is scrambled after DECODE so only the registered copy matters.
        add(1, 'h00, 1, E_Z,        "rst_idle");
        add(0, 'h00, 1, E_Z,        "rel_idle");
        add(0, 'h00, 1, E_FETCH,    "r_fetch");
        add(0, 'h00, 1, E_DEC,      "r_decode");
        add(0, 'h3f, 1, E_EXR,      "r_exec");
        add(0, 'h3f, 1, E_RWB,      "r_wb");
        add(0, 'h3f, 1, E_FETCH,    "lw_fetch");
        add(0, 'h23, 1, E_DEC,      "lw_decode");
        add(0, 'h3f, 1, E_MADDR,    "lw_addr");
        add(0, 'h3f, 0, E_MRD,      "lw_read_wait1");
        add(0, 'h3f, 0, E_MRD,      "lw_read_wait2");
        add(0, 'h3f, 1, E_MRD,      "lw_read");
        add(0, 'h3f, 1, E_MWB,      "lw_wb");
        add(0, 'h3f, 1, E_FETCH,    "bne_fetch");
        add(0, 'h05, 1, E_DEC,      "bne_decode");
        add(0, 'h3f, 1, E_BNE,      "bne_branch");
        add(0, 'h3f, 1, E_FETCH,    "beq_fetch");
        add(0, 'h04, 1, E_DEC,      "beq_decode");
        add(0, 'h05, 1, E_BEQ,      "beq_branch");
        add(0, 'h3f, 1, E_FETCH,    "jal_fetch");
        add(0, 'h03, 1, E_DEC,      "jal_decode");
        add(0, 'h3f, 1, E_JAL,      "jal_jump");
        add(0, 'h3f, 1, E_FETCH,    "j_fetch");
        add(0, 'h02, 1, E_DEC,      "j_decode");
        add(0, 'h03, 1, E_J,        "j_jump");
        add(0, 'h3f, 0, E_FETCH_W,  "ori_fetch_wait");
        add(0, 'h3f, 1, E_FETCH,    "ori_fetch");
        add(0, 'h0d, 1, E_DEC,      "ori_decode");
        add(0, 'h3f, 1, E_EXI_OR,   "ori_exec");
        add(0, 'h3f, 1, E_IWB,      "ori_wb");
        add(0, 'h3f, 1, E_FETCH,    "lui_fetch");
        add(0, 'h0f, 1, E_DEC,      "lui_decode");
        add(0, 'h3f, 1, E_EXI_LUI,  "lui_exec");
        add(0, 'h3f, 1, E_IWB,      "lui_wb");
        add(0, 'h3f, 1, E_FETCH,    "andi_fetch");
        add(0, 'h0c, 1, E_DEC,      "andi_decode");
        add(0, 'h3f, 1, E_EXI_AND,  "andi_exec");
        add(0, 'h3f, 1, E_IWB,      "andi_wb");
        add(0, 'h3f, 1, E_FETCH,    "addi_fetch");
        add(0, 'h08, 1, E_DEC,      "addi_decode");
        add(0, 'h0d, 1, E_EXI_ADD,  "addi_exec");
        add(0, 'h3f, 1, E_IWB,      "addi_wb");
        add(0, 'h3f, 1, E_FETCH,    "ill_fetch");
        add(0, 'h3f, 1, E_DEC_ILL,  "ill_decode");
        add(0, 'h00, 1, E_FETCH,    "ill_refetch");
        add(0, 'h2b, 1, E_DEC,      "sw_decode");
        add(0, 'h3f, 1, E_MADDR,    "sw_addr");
        add(0, 'h3f, 0, E_MWR,      "sw_write_wait");
        add(0, 'h3f, 1, E_MWR_DONE, "sw_write");
        add(0, 'h3f, 1, E_FETCH,    "sw2_fetch");
        add(0, 'h2b, 1, E_DEC,      "sw2_decode");
        add(0, 'h3f, 1, E_MADDR,    "sw2_addr");
        add(0, 'h3f, 0, E_MWR,      "sw2_write_wait");
        add(1, 'h3f, 0, E_MWR,      "sw2_reset_in_write");
        add(1, 'h3f, 0, E_Z,        "reset_hold1");
        add(1, 'h3f, 1, E_Z,        "reset_hold2");
        add(0, 'h3f, 1, E_Z,        "release_idle");
        add(0, 'h3f, 1, E_FETCH,    "release_fetch");

        reset = 1'b1; OP = 6'h00; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            OP        = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, got, vecs[i].exp);
            checks++;
            if (MemRead && MemWrite) begin
                failures++;
                $display("FAIL %s_strobes: MemRead=%0b MemWrite=%0b both high", vecs[i].name, MemRead, MemWrite);
            end
            checks++;
            if (!mem_ready && (RegWrite || PCWrite)) begin
                failures++;
                $display("FAIL %s_stall: RegWrite=%0b PCWrite=%0b with mem_ready=0", vecs[i].name, RegWrite, PCWrite);
            end
        end

        run_count(6'h00, 4, "cycles_rtype");
        run_count(6'h23, 5, "cycles_lw");
        run_count(6'h2b, 4, "cycles_sw");
        run_count(6'h04, 3, "cycles_beq");
        run_count(6'h03, 3, "cycles_jal");
        run_count(6'h0f, 4, "cycles_lui");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
